// File: rtl/uart_word_arbiter.sv
// Two-master round-robin arbiter for a single UART word port: one transaction in flight,
// request fields latched at grant, optional per-transaction response timeout.
module uart_word_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        uart_read,
  output logic        uart_write,
  output logic [31:0] uart_write_data,
  input  logic [31:0] uart_read_data,
  input  logic        uart_response,
  output logic        busy,
  output logic        grant_id
);

  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST =
    (TIMEOUT_CYCLES > 0) ? TIMER_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_id_q, grant_id_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                uart_read_q, uart_read_d;
  logic                uart_write_q, uart_write_d;
  logic [1:0]          ack_q, ack_d;
  logic [1:0]          err_q, err_d;
  logic [1:0][31:0]    rdata_q, rdata_d;
  logic                busy_q, busy_d;

  logic [1:0]          req;
  logic [1:0]          we_in;
  logic [1:0][31:0]    wdata_in;
  logic                win;

  assign req      = {m1_req, m0_req};
  assign we_in    = {m1_we, m0_we};
  assign wdata_in = {m1_wdata, m0_wdata};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    timer_d      = timer_q;
    uart_read_d  = 1'b0;
    uart_write_d = 1'b0;
    ack_d        = '0;
    err_d        = '0;
    rdata_d      = rdata_q;
    win          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          // Contested grants go to whoever did not win last time.
          win          = (req[0] && req[1]) ? ~last_grant_q : req[1];
          grant_id_d   = win;
          last_grant_d = win;
          we_d         = we_in[win];
          wdata_d      = wdata_in[win];
          uart_write_d = we_in[win];
          uart_read_d  = ~we_in[win];
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (timer_q != '1) timer_d = timer_q + TIMER_W'(1);
        if (uart_response) begin
          ack_d[grant_id_q] = 1'b1;
          if (!we_q) rdata_d[grant_id_q] = uart_read_data;
          state_d = ST_DONE;
        end else if (TIMEOUT_CYCLES != 0 && timer_q == TIMER_LAST) begin
          ack_d[grant_id_q] = 1'b1;
          err_d[grant_id_q] = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      timer_q      <= '0;
      uart_read_q  <= 1'b0;
      uart_write_q <= 1'b0;
      ack_q        <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      timer_q      <= timer_d;
      uart_read_q  <= uart_read_d;
      uart_write_q <= uart_write_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign m0_ack          = ack_q[0];
  assign m0_err          = err_q[0];
  assign m0_rdata        = rdata_q[0];
  assign m1_ack          = ack_q[1];
  assign m1_err          = err_q[1];
  assign m1_rdata        = rdata_q[1];
  assign uart_read       = uart_read_q;
  assign uart_write      = uart_write_q;
  assign uart_write_data = wdata_q;
  assign busy            = busy_q;
  assign grant_id        = grant_id_q;

endmodule

// File: tb/tb_uart_word_arbiter.sv
// Directed bench for uart_word_arbiter: a cycle task models both masters and the UART,
// sampling and driving on the falling edge.
module tb_uart_word_arbiter;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_wdata = '0;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_wdata = '0;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdata;
  logic        uart_read, uart_write;
  logic [31:0] uart_write_data;
  logic [31:0] uart_read_data = '0;
  logic        uart_response = 1'b0;
  logic        busy, grant_id;

  uart_word_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .uart_read(uart_read), .uart_write(uart_write), .uart_write_data(uart_write_data),
    .uart_read_data(uart_read_data), .uart_response(uart_response),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int wr_cnt, rd_cnt, m0_ack_cnt, m1_ack_cnt;
  int strobe_time, m0_ack_time, m1_ack_time;
  int resp_cd = 0, uart_delay = 2;
  int m0_left = 0, m1_left = 0;
  bit mute = 1'b0, late_pulse = 1'b0;
  logic m0_err_seen, m1_err_seen;
  logic [31:0] rd_word = '0, resp_wdata, m0_rdata_at_ack, m1_rdata_at_ack;
  bit grant_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: observe DUT outputs, then drive UART response and master req for the next edge.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (uart_write) wr_cnt++;
    if (uart_read) rd_cnt++;
    if (uart_write || uart_read) begin
      strobe_time = cyc;
      grant_log.push_back(grant_id);
    end
    if (m0_ack) begin
      m0_ack_cnt++; m0_ack_time = cyc; m0_err_seen = m0_err; m0_rdata_at_ack = m0_rdata;
    end
    if (m1_ack) begin
      m1_ack_cnt++; m1_ack_time = cyc; m1_err_seen = m1_err; m1_rdata_at_ack = m1_rdata;
    end
    uart_response = 1'b0;
    if (late_pulse) begin
      uart_response = 1'b1;
      late_pulse = 1'b0;
    end
    if (resp_cd > 0) begin
      resp_cd--;
      if (resp_cd == 0) begin
        uart_response  = 1'b1;
        uart_read_data = rd_word;
        resp_wdata     = uart_write_data;
      end
    end
    if ((uart_write || uart_read) && !mute) resp_cd = uart_delay - 1;
    if (m0_ack && m0_left > 0) begin
      m0_left--;
      if (m0_left == 0) m0_req = 1'b0;
    end
    if (m1_ack && m1_left > 0) begin
      m1_left--;
      if (m1_left == 0) m1_req = 1'b0;
    end
  endtask

  task automatic clear_stats();
    wr_cnt = 0; rd_cnt = 0; m0_ack_cnt = 0; m1_ack_cnt = 0;
    strobe_time = -1; m0_ack_time = -1; m1_ack_time = -1;
    m0_err_seen = 1'bx; m1_err_seen = 1'bx;
    m0_rdata_at_ack = 'x; m1_rdata_at_ack = 'x; resp_wdata = 'x;
    grant_log.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    m0_left = 0; m1_left = 0; resp_cd = 0; mute = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic run_until_acks(input int m0_target, input int m1_target, input int budget);
    for (int n = 0; n < budget && (m0_ack_cnt < m0_target || m1_ack_cnt < m1_target); n++) cycle();
  endtask

  task automatic run_until_strobe(input int budget);
    for (int n = 0; n < budget && (wr_cnt + rd_cnt) == 0; n++) cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int c0;
  logic [3:0] seq;

  initial begin
    clear_stats();
    do_reset();

    // Reset state
    check("rst_busy",    32'(busy), 0);
    check("rst_grant",   32'(grant_id), 0);
    check("rst_strobes", 32'({uart_read, uart_write}), 0);
    check("rst_acks",    32'({m0_ack, m1_ack, m0_err, m1_err}), 0);
    check("rst_m0_rd",   m0_rdata, 0);
    check("rst_m1_rd",   m1_rdata, 0);
    check("rst_wdata",   uart_write_data, 0);

    // 1: m0 write, UART answers 5 cycles after the strobe
    clear_stats();
    uart_delay = 5;
    m0_we = 1'b1; m0_wdata = 32'hDEADBEEF; m0_req = 1'b1; m0_left = 1;
    c0 = cyc;
    run_until_acks(1, 0, 50);
    idle(4);
    check("t1_req2strobe", strobe_time, c0 + 1);
    check("t1_wr_cnt",     wr_cnt, 1);
    check("t1_rd_cnt",     rd_cnt, 0);
    check("t1_uart_word",  resp_wdata, 32'hDEADBEEF);
    check("t1_ack_cnt",    m0_ack_cnt, 1);
    check("t1_ack_lat",    m0_ack_time - strobe_time, 5);
    check("t1_err",        32'(m0_err_seen), 0);
    check("t1_m1_ack",     m1_ack_cnt, 0);
    check("t1_m1_rdata",   m1_rdata, 0);
    check("t1_grant",      32'(grant_id), 0);
    check("t1_busy_end",   32'(busy), 0);

    // 2: m1 read returning 0x12345678
    clear_stats();
    uart_delay = 3; rd_word = 32'h12345678;
    m1_we = 1'b0; m1_req = 1'b1; m1_left = 1;
    run_until_acks(0, 1, 50);
    idle(4);
    check("t2_rd_cnt",      rd_cnt, 1);
    check("t2_wr_cnt",      wr_cnt, 0);
    check("t2_ack_cnt",     m1_ack_cnt, 1);
    check("t2_rdata_ack",   m1_rdata_at_ack, 32'h12345678);
    check("t2_err",         32'(m1_err_seen), 0);
    check("t2_m0_rdata",    m0_rdata, 0);
    check("t2_m0_ack",      m0_ack_cnt, 0);
    check("t2_grant",       32'(grant_id), 1);

    // 3: both request together from reset, four transactions alternate 0,1,0,1
    do_reset();
    clear_stats();
    uart_delay = 2; rd_word = 32'hA5A55A5A;
    m0_we = 1'b0; m1_we = 1'b1; m1_wdata = 32'h11112222;
    m0_req = 1'b1; m1_req = 1'b1; m0_left = 2; m1_left = 2;
    run_until_acks(2, 2, 100);
    idle(4);
    seq = '1;
    for (int i = 0; i < 4 && i < grant_log.size(); i++) seq[3-i] = grant_log[i];
    check("t3_strobes",   wr_cnt + rd_cnt, 4);
    check("t3_grant_seq", 32'(seq), 32'h5);
    check("t3_m0_acks",   m0_ack_cnt, 2);
    check("t3_m1_acks",   m1_ack_cnt, 2);
    check("t3_m0_rdata",  m0_rdata, 32'hA5A55A5A);
    check("t3_m1_rdata",  m1_rdata, 0);

    // 4: UART never answers; timeout ack 16 cycles after the UART samples the strobe
    clear_stats();
    mute = 1'b1;
    m0_we = 1'b1; m0_wdata = 32'hCAFE0001; m0_req = 1'b1; m0_left = 1;
    run_until_acks(1, 0, 60);
    check("t4_ack_cnt",   m0_ack_cnt, 1);
    check("t4_err",       32'(m0_err_seen), 1);
    check("t4_ack_lat",   m0_ack_time - strobe_time, 17);
    check("t4_m0_rdata",  m0_rdata, 32'hA5A55A5A);
    late_pulse = 1'b1;
    idle(5);
    check("t4_late_acks", m0_ack_cnt + m1_ack_cnt, 1);
    check("t4_late_strb", wr_cnt + rd_cnt, 1);
    check("t4_late_busy", 32'(busy), 0);

    // 5: reset while waiting, then a fresh m1 read
    clear_stats();
    mute = 1'b1;
    m0_we = 1'b1; m0_wdata = 32'h0F0F0F0F; m0_req = 1'b1; m0_left = 1;
    run_until_strobe(20);
    idle(3);
    check("t5_busy_wait", 32'(busy), 1);
    reset = 1'b1; m0_req = 1'b0; m0_left = 0;
    cycle();
    check("t5_busy_rst",  32'(busy), 0);
    check("t5_no_ack",    m0_ack_cnt + m1_ack_cnt, 0);
    check("t5_strobes",   32'({uart_read, uart_write}), 0);
    check("t5_rdata_clr", m0_rdata, 0);
    reset = 1'b0;
    mute = 1'b0;
    clear_stats();
    uart_delay = 4; rd_word = 32'h0BADF00D;
    m1_we = 1'b0; m1_req = 1'b1; m1_left = 1;
    run_until_acks(0, 1, 50);
    idle(3);
    check("t5_m1_ack",    m1_ack_cnt, 1);
    check("t5_m1_rdata",  m1_rdata_at_ack, 32'h0BADF00D);
    check("t5_m1_err",    32'(m1_err_seen), 0);
    check("t5_m0_ack",    m0_ack_cnt, 0);

    // 6: m0 changes its inputs after grant; the UART keeps the latched word
    clear_stats();
    uart_delay = 6;
    m0_we = 1'b1; m0_wdata = 32'h55AA55AA; m0_req = 1'b1; m0_left = 1;
    run_until_strobe(20);
    m0_wdata = 32'h0; m0_we = 1'b0;
    run_until_acks(1, 0, 50);
    idle(6);
    check("t6_uart_word", resp_wdata, 32'h55AA55AA);
    check("t6_wr_cnt",    wr_cnt, 1);
    check("t6_rd_cnt",    rd_cnt, 0);
    check("t6_ack_cnt",   m0_ack_cnt, 1);
    check("t6_busy_end",  32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
